// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage core.
//
// Sits behind the EX/MEM register. It turns the registered load/store fields
// into a request/grant/response transaction on the data bus. Store data is
// lane-replicated with matching byte enables, and load data is shifted down
// and then sign- or zero-extended. Misaligned accesses are trapped without
// touching the bus. The stage owns the MEM/WB register.
//
// Ports
//   clk, cpurst           : core clock, asynchronous active-high reset
//   ex2mem_*_ffout        : registered EX/MEM fields (rd, ALU result, address,
//                           store data, funct3, access kind, exception, PC)
//   dbus_req/we/addr/wdata/be : bus request side, held stable until dbus_gnt
//   dbus_gnt              : request accepted (ignored while dbus_req=0)
//   dbus_rvalid/rdata     : load response (ignored outside RESP)
//   mem_stall             : holds EX/MEM and upstream while an access is open
//   mem2wb_*              : MEM/WB register outputs
//   dbg_state             : current FSM state (0 IDLE, 1 REQ, 2 RESP)
//
// Handshake: a bus transfer happens in a cycle with dbus_req=1 and dbus_gnt=1.
// A load completes later in the single cycle with dbus_rvalid=1 while in RESP.
module mem_stage (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        ex2mem_wr_reg_ffout,
    input  logic [4:0]  ex2mem_wr_regindex_ffout,
    input  logic [31:0] ex2mem_wr_wdata_ffout,
    input  logic [31:0] ex2mem_memaddr_ffout,
    input  logic [31:0] ex2mem_wr_memwdata_ffout,
    input  logic [2:0]  ex2mem_mem_op_ffout,
    input  logic        ex2mem_mem_en_ffout,
    input  logic        ex2mem_load_ffout,
    input  logic        ex2mem_store_ffout,
    input  logic        ex2mem_exp_ffout,
    input  logic [31:0] ex2mem_pc_ffout,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic        mem_stall,
    output logic        mem2wb_wr_reg,
    output logic [4:0]  mem2wb_wr_regindex,
    output logic [31:0] mem2wb_wr_wdata,
    output logic        mem2wb_exp_ffout,
    output logic        mem2wb_misalign,
    output logic [31:0] mem2wb_badaddr,
    output logic [31:0] mem2wb_pc,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        aligned;
    logic        active;
    logic        mis_acc;
    logic        done_now;
    logic [31:0] shifted;
    logic [31:0] load_data;

    // Reserved funct3 encodings (011, 110, 111) are treated as misaligned so
    // they trap instead of reaching the bus.
    always_comb begin
        aligned = 1'b0;
        case (ex2mem_mem_op_ffout)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = ~ex2mem_memaddr_ffout[0];
            3'b010:         aligned = (ex2mem_memaddr_ffout[1:0] == 2'b00);
            default:        aligned = 1'b0;
        endcase
    end

    assign active  = ex2mem_mem_en_ffout & ~ex2mem_exp_ffout & aligned;
    assign mis_acc = ex2mem_mem_en_ffout & ~ex2mem_exp_ffout & ~aligned;

    // The access finishes this cycle: a store on grant, a load on its response.
    always_comb begin
        done_now = 1'b0;
        case (state)
            IDLE:    done_now = active & dbus_gnt & ex2mem_store_ffout;
            REQ:     done_now = dbus_gnt & ex2mem_store_ffout;
            RESP:    done_now = dbus_rvalid;
            default: done_now = 1'b0;
        endcase
    end

    // Reset gates the combinational outputs so that an aborted transaction
    // releases the bus and the pipeline in the same cycle.
    assign mem_stall = ~cpurst & active & ~done_now;
    assign dbus_req  = ~cpurst & (((state == IDLE) & active) | (state == REQ));
    assign dbus_we   = ex2mem_store_ffout;
    assign dbus_addr = {ex2mem_memaddr_ffout[31:2], 2'b00};
    assign dbg_state = state;

    always_comb begin
        dbus_wdata = ex2mem_wr_memwdata_ffout;
        dbus_be    = 4'b1111;
        case (ex2mem_mem_op_ffout[1:0])
            2'b00: begin
                dbus_wdata = {4{ex2mem_wr_memwdata_ffout[7:0]}};
                dbus_be    = 4'b0001 << ex2mem_memaddr_ffout[1:0];
            end
            2'b01: begin
                dbus_wdata = {2{ex2mem_wr_memwdata_ffout[15:0]}};
                dbus_be    = ex2mem_memaddr_ffout[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                dbus_wdata = ex2mem_wr_memwdata_ffout;
                dbus_be    = 4'b1111;
            end
        endcase
    end

    assign shifted = dbus_rdata >> {ex2mem_memaddr_ffout[1:0], 3'b000};

    always_comb begin
        load_data = shifted;
        case (ex2mem_mem_op_ffout)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (active) begin
                        if (dbus_gnt) state <= ex2mem_store_ffout ? IDLE : RESP;
                        else          state <= REQ;
                    end
                end
                REQ: begin
                    if (dbus_gnt) state <= ex2mem_store_ffout ? IDLE : RESP;
                end
                RESP: begin
                    if (dbus_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // MEM/WB register. A stalled cycle inserts a bubble. An exception, whether
    // it came from upstream or is a local misalignment, suppresses the rd write.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            mem2wb_wr_reg      <= 1'b0;
            mem2wb_wr_regindex <= 5'd0;
            mem2wb_wr_wdata    <= 32'd0;
            mem2wb_exp_ffout   <= 1'b0;
            mem2wb_misalign    <= 1'b0;
            mem2wb_badaddr     <= 32'd0;
            mem2wb_pc          <= 32'd0;
        end else begin
            mem2wb_pc <= ex2mem_pc_ffout;
            if (mem_stall) begin
                mem2wb_wr_reg    <= 1'b0;
                mem2wb_exp_ffout <= 1'b0;
                mem2wb_misalign  <= 1'b0;
            end else begin
                mem2wb_wr_reg      <= ex2mem_wr_reg_ffout & ~ex2mem_exp_ffout & ~mis_acc;
                mem2wb_wr_regindex <= ex2mem_wr_regindex_ffout;
                mem2wb_wr_wdata    <= (active & ex2mem_load_ffout) ? load_data
                                                                    : ex2mem_wr_wdata_ffout;
                mem2wb_exp_ffout   <= ex2mem_exp_ffout | mis_acc;
                mem2wb_misalign    <= mis_acc;
                mem2wb_badaddr     <= ex2mem_memaddr_ffout;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage. Stimulus pushes the expected bus transfers
// and MEM/WB results into queues. A negedge monitor compares them whenever the
// DUT requests the bus or presents a writeback/exception.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        cpurst = 1'b1;
    logic        ex_wr_reg = 1'b0;
    logic [4:0]  ex_idx = '0;
    logic [31:0] ex_wdata = '0;
    logic [31:0] ex_addr = '0;
    logic [31:0] ex_sdata = '0;
    logic [2:0]  ex_op = '0;
    logic        ex_en = 1'b0;
    logic        ex_ld = 1'b0;
    logic        ex_st = 1'b0;
    logic        ex_exp = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_gnt = 1'b0;
    logic        dbus_rvalid = 1'b0;
    logic [31:0] dbus_rdata = '0;
    logic        mem_stall;
    logic        mem2wb_wr_reg, mem2wb_exp_ffout, mem2wb_misalign;
    logic [4:0]  mem2wb_wr_regindex;
    logic [31:0] mem2wb_wr_wdata, mem2wb_badaddr, mem2wb_pc;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // bus entry: {we, addr, wdata, be}; wb entry: {wr_reg, idx, wdata, exp, misalign, badaddr}
    logic [68:0] bus_q[$];
    logic [68:0] bus_mask_q[$];
    logic [71:0] wb_q[$];
    logic [71:0] wb_mask_q[$];

    mem_stage dut (
        .clk                      (clk),
        .cpurst                   (cpurst),
        .ex2mem_wr_reg_ffout      (ex_wr_reg),
        .ex2mem_wr_regindex_ffout (ex_idx),
        .ex2mem_wr_wdata_ffout    (ex_wdata),
        .ex2mem_memaddr_ffout     (ex_addr),
        .ex2mem_wr_memwdata_ffout (ex_sdata),
        .ex2mem_mem_op_ffout      (ex_op),
        .ex2mem_mem_en_ffout      (ex_en),
        .ex2mem_load_ffout        (ex_ld),
        .ex2mem_store_ffout       (ex_st),
        .ex2mem_exp_ffout         (ex_exp),
        .ex2mem_pc_ffout          (ex_pc),
        .dbus_req                 (dbus_req),
        .dbus_we                  (dbus_we),
        .dbus_addr                (dbus_addr),
        .dbus_wdata               (dbus_wdata),
        .dbus_be                  (dbus_be),
        .dbus_gnt                 (dbus_gnt),
        .dbus_rvalid              (dbus_rvalid),
        .dbus_rdata               (dbus_rdata),
        .mem_stall                (mem_stall),
        .mem2wb_wr_reg            (mem2wb_wr_reg),
        .mem2wb_wr_regindex       (mem2wb_wr_regindex),
        .mem2wb_wr_wdata          (mem2wb_wr_wdata),
        .mem2wb_exp_ffout         (mem2wb_exp_ffout),
        .mem2wb_misalign          (mem2wb_misalign),
        .mem2wb_badaddr           (mem2wb_badaddr),
        .mem2wb_pc                (mem2wb_pc),
        .dbg_state                (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!cpurst) begin
            if (dbus_req) begin
                if (bus_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL bus_unexpected: got request to 0x%08h, expected none", dbus_addr);
                end else begin
                    check("bus", {3'b000, {dbus_we, dbus_addr, dbus_wdata, dbus_be} & bus_mask_q[0]},
                          {3'b000, bus_q[0] & bus_mask_q[0]});
                    if (dbus_gnt) begin
                        void'(bus_q.pop_front());
                        void'(bus_mask_q.pop_front());
                    end
                end
            end
            if (mem2wb_wr_reg || mem2wb_exp_ffout) begin
                if (wb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL wb_unexpected: got wr_reg=%0b exp=%0b, expected no output",
                             mem2wb_wr_reg, mem2wb_exp_ffout);
                end else begin
                    check("wb", {mem2wb_wr_reg, mem2wb_wr_regindex, mem2wb_wr_wdata, mem2wb_exp_ffout,
                                 mem2wb_misalign, mem2wb_badaddr} & wb_mask_q[0],
                          wb_q[0] & wb_mask_q[0]);
                    void'(wb_q.pop_front());
                    void'(wb_mask_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_op(input logic wr, input logic [4:0] idx, input logic [31:0] wd,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [2:0] op,
                          input logic en, input logic ld, input logic st, input logic ex,
                          input logic [31:0] pc);
        ex_wr_reg = wr; ex_idx = idx; ex_wdata = wd; ex_addr = addr; ex_sdata = sd;
        ex_op = op; ex_en = en; ex_ld = ld; ex_st = st; ex_exp = ex; ex_pc = pc;
    endtask

    task automatic clear_op();
        set_op(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // Loads compare only we and address; store entries compare everything.
    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be);
        bus_q.push_back({we, addr, wd, be});
        bus_mask_q.push_back(we ? {69{1'b1}} : {1'b1, 32'hFFFF_FFFF, 32'd0, 4'd0});
    endtask

    task automatic push_wb(input logic wr, input logic [4:0] idx, input logic [31:0] wd,
                           input logic ex, input logic mis, input logic [31:0] bad,
                           input logic chk_wr);
        logic [71:0] m;
        m = {chk_wr, {5{wr}}, {32{wr}}, 1'b1, 1'b1, {32{mis}}};
        wb_q.push_back({wr, idx, wd, ex, mis, bad});
        wb_mask_q.push_back(m);
    endtask

    // Runs the currently driven instruction until mem_stall drops. Grant
    // arrives gd cycles after the start and rvalid rd cycles after the grant.
    task automatic run_op(input int gd, input int rd, input logic is_load,
                          output int stalls, output int reqs);
        logic st;
        logic fin;
        fin = 1'b0;
        stalls = 0;
        reqs = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            dbus_gnt = (c >= gd);
            dbus_rvalid = is_load && (c == gd + rd);
            @(negedge clk);
            st = mem_stall;
            if (st) stalls++;
            if (dbus_req) reqs++;
            if (c > 0) check("stall_bubble", {70'd0, mem2wb_wr_reg, mem2wb_exp_ffout}, 72'd0);
            @(posedge clk);
            #1;
            if (!st) fin = 1'b1;
        end
        if (!fin) begin
            n_vec++;
            n_err++;
            $display("FAIL op_timeout: got mem_stall=1 after 40 cycles, expected release");
        end
        dbus_gnt = 1'b0;
        dbus_rvalid = 1'b0;
        clear_op();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s, r;
        #3;
        check("rst_req",   {71'd0, dbus_req}, 72'd0);
        check("rst_stall", {71'd0, mem_stall}, 72'd0);
        check("rst_state", {70'd0, dbg_state}, 72'd0);
        check("rst_wb", {mem2wb_wr_reg, mem2wb_wr_regindex, mem2wb_wr_wdata, mem2wb_exp_ffout,
                         mem2wb_misalign, mem2wb_badaddr}, 72'd0);
        check("rst_pc", {40'd0, mem2wb_pc}, 72'd0);
        @(posedge clk); #1;
        cpurst = 1'b0;

        // non-memory op
        set_op(1'b1, 5'd5, 32'h1234, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
        push_wb(1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 32'h0, 1'b1);
        run_op(0, 0, 1'b0, s, r);
        check("nonmem_stall", s, 0);
        check("nonmem_req", r, 0);
        @(negedge clk);
        check("nonmem_pc", {40'd0, mem2wb_pc}, 72'h100);
        @(posedge clk); #1;

        // SB 0x1003
        set_op(1'b0, 5'd0, 32'h0, 32'h1003, 32'h0000_00A5, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104);
        push_bus(1'b1, 32'h1000, 32'hA5A5_A5A5, 4'b1000);
        run_op(0, 0, 1'b0, s, r);
        check("sb_stall", s, 0);
        check("sb_req", r, 1);

        // SH 0x1002, one wait state
        set_op(1'b0, 5'd0, 32'h0, 32'h1002, 32'h1234_ABCD, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h108);
        push_bus(1'b1, 32'h1000, 32'hABCD_ABCD, 4'b1100);
        run_op(1, 0, 1'b0, s, r);
        check("sh_stall", s, 1);
        check("sh_req", r, 2);

        // LH 0x2002
        dbus_rdata = 32'h80F0_0000;
        set_op(1'b1, 5'd7, 32'h0, 32'h2002, 32'h0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10C);
        push_bus(1'b0, 32'h2000, 32'h0, 4'h0);
        push_wb(1'b1, 5'd7, 32'hFFFF_80F0, 1'b0, 1'b0, 32'h0, 1'b1);
        run_op(0, 1, 1'b1, s, r);
        check("lh_stall", s, 1);

        // LHU 0x2002
        set_op(1'b1, 5'd8, 32'h0, 32'h2002, 32'h0, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0, 32'h110);
        push_bus(1'b0, 32'h2000, 32'h0, 4'h0);
        push_wb(1'b1, 5'd8, 32'h0000_80F0, 1'b0, 1'b0, 32'h0, 1'b1);
        run_op(0, 1, 1'b1, s, r);
        check("lhu_stall", s, 1);

        // SW with grant withheld 3 cycles (wr_reg set so bubbles are visible)
        set_op(1'b1, 5'd9, 32'h55, 32'h1004, 32'hCAFE_F00D, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 32'h114);
        push_bus(1'b1, 32'h1004, 32'hCAFE_F00D, 4'b1111);
        push_wb(1'b1, 5'd9, 32'h55, 1'b0, 1'b0, 32'h0, 1'b1);
        run_op(3, 0, 1'b0, s, r);
        check("sw_wait_stall", s, 3);
        check("sw_wait_req", r, 4);

        // misaligned LW 0x3001
        set_op(1'b1, 5'd10, 32'h0, 32'h3001, 32'h0, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h118);
        push_wb(1'b0, 5'd10, 32'h0, 1'b1, 1'b1, 32'h3001, 1'b1);
        run_op(0, 0, 1'b1, s, r);
        check("lw_mis_req", r, 0);
        check("lw_mis_stall", s, 0);

        // LB 0x1001, response two cycles after grant
        dbus_rdata = 32'h1234_F600;
        set_op(1'b1, 5'd11, 32'h0, 32'h1001, 32'h0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11C);
        push_bus(1'b0, 32'h1000, 32'h0, 4'h0);
        push_wb(1'b1, 5'd11, 32'hFFFF_FFF6, 1'b0, 1'b0, 32'h0, 1'b1);
        run_op(0, 2, 1'b1, s, r);
        check("lb_stall", s, 2);

        // LBU 0x1001, grant after 2 cycles, response 1 later
        set_op(1'b1, 5'd12, 32'h0, 32'h1001, 32'h0, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 32'h120);
        push_bus(1'b0, 32'h1000, 32'h0, 4'h0);
        push_wb(1'b1, 5'd12, 32'h0000_00F6, 1'b0, 1'b0, 32'h0, 1'b1);
        run_op(2, 1, 1'b1, s, r);
        check("lbu_stall", s, 3);
        check("lbu_req", r, 3);

        // LW 0x4000, response 3 cycles after grant
        dbus_rdata = 32'hDEAD_BEEF;
        set_op(1'b1, 5'd13, 32'h0, 32'h4000, 32'h0, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h124);
        push_bus(1'b0, 32'h4000, 32'h0, 4'h0);
        push_wb(1'b1, 5'd13, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b1);
        run_op(0, 3, 1'b1, s, r);
        check("lw_stall", s, 3);
        check("lw_req", r, 1);

        // reserved funct3 011 traps as misaligned
        set_op(1'b1, 5'd14, 32'h0, 32'h1000, 32'h0, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 32'h128);
        push_wb(1'b0, 5'd14, 32'h0, 1'b1, 1'b1, 32'h1000, 1'b1);
        run_op(0, 0, 1'b1, s, r);
        check("op011_req", r, 0);

        // upstream exception on an aligned store
        set_op(1'b0, 5'd0, 32'h0, 32'h1008, 32'h1111_2222, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 32'h12C);
        push_wb(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        run_op(0, 0, 1'b0, s, r);
        check("upexp_req", r, 0);
        check("upexp_stall", s, 0);

        // reset while waiting in RESP
        set_op(1'b1, 5'd15, 32'h0, 32'h5000, 32'h0, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h130);
        push_bus(1'b0, 32'h5000, 32'h0, 4'h0);
        dbus_gnt = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        dbus_gnt = 1'b0;
        @(negedge clk);
        check("resp_stall", {71'd0, mem_stall}, 72'd1);
        check("resp_state", {70'd0, dbg_state}, 72'd2);
        #2;
        cpurst = 1'b1;
        #1;
        check("arst_req",   {71'd0, dbus_req}, 72'd0);
        check("arst_stall", {71'd0, mem_stall}, 72'd0);
        check("arst_state", {70'd0, dbg_state}, 72'd0);
        check("arst_wb", {mem2wb_wr_reg, mem2wb_wr_regindex, mem2wb_wr_wdata, mem2wb_exp_ffout,
                          mem2wb_misalign, mem2wb_badaddr}, 72'd0);
        check("arst_pc", {40'd0, mem2wb_pc}, 72'd0);
        @(posedge clk); #1;
        clear_op();
        @(posedge clk); #1;
        cpurst = 1'b0;
        dbus_rdata = 32'hFFFF_FFFF;
        dbus_rvalid = 1'b1;
        @(negedge clk);
        check("late_rvalid_state", {70'd0, dbg_state}, 72'd0);
        check("late_rvalid_stall", {71'd0, mem_stall}, 72'd0);
        @(posedge clk); #1;
        dbus_rvalid = 1'b0;
        @(negedge clk);
        check("late_rvalid_wb", {71'd0, mem2wb_wr_reg}, 72'd0);
        check("late_rvalid_state2", {70'd0, dbg_state}, 72'd0);

        repeat (2) @(posedge clk);
        #1;
        check("bus_q_drained", bus_q.size(), 0);
        check("wb_q_drained", wb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
